// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the mtm_Alu serial link (deserializer and serializer).
// Frame: start(0), type, 8 payload bits MSB first, stop(1). CTL payload is
// {1'b0, op[2:0], crc[3:0]}.
package mtm_alu_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StType,
      StPayload,
      StStop
   } state_e;

   localparam logic FRAME_DATA = 1'b0;
   localparam logic FRAME_CTL  = 1'b1;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

   localparam int unsigned FRAME_BITS  = 11;
   localparam int unsigned CTL_OP_MSB  = 6;
   localparam int unsigned CTL_OP_LSB  = 4;
   localparam int unsigned CTL_CRC_MSB = 3;
   localparam int unsigned CTL_CRC_LSB = 0;

endpackage

// File: rtl/mtm_alu_sync.sv
// Input synchronizer for the idle-high serial line.
// Ports: clk, rst_n (async, active low), d (asynchronous input), q (synchronized).
// Every stage resets to 1 so a reset never looks like a start bit.
module mtm_alu_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Receive side of the mtm_Alu serial link: turns the sin bit stream into
// operands A/B, opcode and CRC.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sin                 serial input, idles high
//   a_out, b_out        operands, updated with valid
//   op, crc             CTL frame fields, updated with valid
//   valid               one-cycle pulse, new packet decoded
//   err_data            one-cycle pulse, CTL frame after wrong data-frame count
//   err_frame           one-cycle pulse, stop bit sampled low
module mtm_alu_deserializer
   import mtm_alu_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned N_DATA      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sin,
   output logic [31:0] a_out,
   output logic [31:0] b_out,
   output logic [2:0]  op,
   output logic [3:0]  crc,
   output logic        valid,
   output logic        err_data,
   output logic        err_frame
);

   // Must hold N_DATA+1, the saturation value.
   localparam int unsigned CntW = $clog2(N_DATA + 2);

   logic sin_s;

   mtm_alu_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sin),
      .q    (sin_s)
   );

   state_e          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
   logic            type_q, type_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      staging_q [8];
   logic [7:0]      staging_d [8];
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic [3:0]      crc_q, crc_d;
   logic            valid_q, valid_d;
   logic            err_data_q, err_data_d;
   logic            err_frame_q, err_frame_d;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      frame_cnt_d = frame_cnt_q;
      type_d      = type_q;
      shift_d     = shift_q;
      staging_d   = staging_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      crc_d       = crc_q;
      valid_d     = 1'b0;
      err_data_d  = 1'b0;
      err_frame_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (sin_s == START_BIT) state_d = StType;
         end
         StType: begin
            type_d    = sin_s;
            bit_cnt_d = '0;
            state_d   = StPayload;
         end
         StPayload: begin
            shift_d   = {shift_q[6:0], sin_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = StStop;
         end
         StStop: begin
            state_d = StIdle;
            if (sin_s == STOP_BIT) begin
               if (type_q == FRAME_DATA) begin
                  // Surplus frames are counted (for err_data) but not stored.
                  for (int unsigned i = 0; i < 8; i++) begin
                     if (i < N_DATA && frame_cnt_q == CntW'(i)) staging_d[i] = shift_q;
                  end
                  if (frame_cnt_q != CntW'(N_DATA + 1)) frame_cnt_d = frame_cnt_q + 1'b1;
               end else begin
                  frame_cnt_d = '0;
                  if (frame_cnt_q == CntW'(N_DATA)) begin
                     b_d     = {staging_q[0], staging_q[1], staging_q[2], staging_q[3]};
                     a_d     = {staging_q[4], staging_q[5], staging_q[6], staging_q[7]};
                     op_d    = shift_q[CTL_OP_MSB:CTL_OP_LSB];
                     crc_d   = shift_q[CTL_CRC_MSB:CTL_CRC_LSB];
                     valid_d = 1'b1;
                  end else begin
                     err_data_d = 1'b1;
                  end
               end
            end else begin
               // Bad stop bit: drop the packet in progress.
               err_frame_d = 1'b1;
               frame_cnt_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         frame_cnt_q <= '0;
         type_q      <= FRAME_DATA;
         shift_q     <= '0;
         staging_q   <= '{default: '0};
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         crc_q       <= '0;
         valid_q     <= 1'b0;
         err_data_q  <= 1'b0;
         err_frame_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         type_q      <= type_d;
         shift_q     <= shift_d;
         staging_q   <= staging_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         crc_q       <= crc_d;
         valid_q     <= valid_d;
         err_data_q  <= err_data_d;
         err_frame_q <= err_frame_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign op        = op_q;
   assign crc       = crc_q;
   assign valid     = valid_q;
   assign err_data  = err_data_q;
   assign err_frame = err_frame_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Self-checking bench for mtm_alu_deserializer: packet table plus hand-written
// corner sequences; expected pulses go through a scoreboard queue.
module tb_mtm_alu_deserializer;

   localparam int unsigned SYNC  = 2;
   localparam int unsigned NDATA = 8;

   localparam int EV_VALID = 0;
   localparam int EV_ERR_DATA = 1;
   localparam int EV_ERR_FRAME = 2;

   typedef struct {
      logic [31:0] b;
      logic [31:0] a;
      logic [2:0]  op;
      logic [3:0]  crc;
      int          ndata;
      int          gap_lo;
      int          gap_hi;
      logic        bit7;
   } vec_t;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [3:0]  crc;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sin = 1'b1;
   logic [31:0] a_out, b_out;
   logic [2:0]  op;
   logic [3:0]  crc;
   logic        valid, err_data, err_frame;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   exp_t sb[$];

   // Reference copy of the output registers.
   logic [31:0] mdl_a = '0, mdl_b = '0;
   logic [2:0]  mdl_op = '0;
   logic [3:0]  mdl_crc = '0;

   vec_t vecs[7];

   mtm_alu_deserializer #(
      .SYNC_STAGES(SYNC),
      .N_DATA     (NDATA)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sin      (sin),
      .a_out    (a_out),
      .b_out    (b_out),
      .op       (op),
      .crc      (crc),
      .valid    (valid),
      .err_data (err_data),
      .err_frame(err_frame)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Every pulse is matched against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      int   kind;
      if (rst_n && (valid || err_data || err_frame)) begin
         chk("pulses_exclusive", 64'(int'(valid) + int'(err_data) + int'(err_frame)), 64'd1);
         kind = valid ? EV_VALID : (err_data ? EV_ERR_DATA : EV_ERR_FRAME);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: got kind %0d, expected no pulse (cycle %0d)",
                     kind, cyc);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", 64'(kind), 64'(e.kind));
            chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            chk("a_out", 64'(a_out), 64'(e.a));
            chk("b_out", 64'(b_out), 64'(e.b));
            chk("op", 64'(op), 64'(e.op));
            chk("crc", 64'(crc), 64'(e.crc));
         end
      end
   end

   task automatic drive_bit(input logic v);
      @(posedge clk);
      #1 sin = v;
   endtask

   task automatic idle(input int n);
      repeat (n) drive_bit(1'b1);
   endtask

   task automatic send_frame(input logic is_ctl, input logic [7:0] pl, input logic stop,
                             output int stop_cyc);
      drive_bit(1'b0);
      drive_bit(is_ctl);
      for (int i = 7; i >= 0; i--) drive_bit(pl[i]);
      drive_bit(stop);
      stop_cyc = cyc;
   endtask

   // Stop bit driven during cycle c ends at edge c+1; pulse registers SYNC edges later.
   task automatic push(input int kind, input int stop_cyc);
      exp_t e;
      e.kind = kind;
      e.a    = mdl_a;
      e.b    = mdl_b;
      e.op   = mdl_op;
      e.crc  = mdl_crc;
      e.cyc  = stop_cyc + 1 + int'(SYNC);
      sb.push_back(e);
   endtask

   function automatic logic [7:0] data_byte(input vec_t v, input int i);
      logic [63:0] ba;
      ba = {v.b, v.a};
      if (i < 8) return ba[63 - 8 * i -: 8];
      return 8'($urandom);
   endfunction

   task automatic send_packet(input vec_t v);
      int sc;
      for (int i = 0; i < v.ndata; i++) begin
         send_frame(1'b0, data_byte(v, i), 1'b1, sc);
         idle(int'($urandom_range(v.gap_hi, v.gap_lo)));
      end
      send_frame(1'b1, {v.bit7, v.op, v.crc}, 1'b1, sc);
      if (v.ndata == int'(NDATA)) begin
         mdl_a   = v.a;
         mdl_b   = v.b;
         mdl_op  = v.op;
         mdl_crc = v.crc;
         push(EV_VALID, sc);
      end else begin
         push(EV_ERR_DATA, sc);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a_out"}, 64'(a_out), 64'd0);
      chk({tag, "_b_out"}, 64'(b_out), 64'd0);
      chk({tag, "_op"}, 64'(op), 64'd0);
      chk({tag, "_crc"}, 64'(crc), 64'd0);
      chk({tag, "_pulses"}, 64'({valid, err_data, err_frame}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      vecs[0] = '{32'h0000_0002, 32'h0000_0003, 3'd0, 4'hA, 8, 0, 0, 1'b0};
      vecs[1] = '{32'hCAFE_F00D, 32'h0BAD_C0DE, 3'd1, 4'h2, 7, 0, 2, 1'b0};
      vecs[2] = '{32'h1122_3344, 32'h5566_7788, 3'd5, 4'h1, 8, 0, 0, 1'b0};
      vecs[3] = '{32'h0102_0304, 32'h0506_0708, 3'd2, 4'h3, 9, 0, 0, 1'b0};
      vecs[4] = '{32'hDEAD_BEEF, 32'h1234_5678, 3'd3, 4'hC, 8, 0, 0, 1'b0};
      vecs[5] = '{32'hFFFF_FFFF, 32'h8000_0000, 3'd7, 4'hF, 8, 1, 20, 1'b1};
      vecs[6] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'd6, 4'h5, 8, 0, 3, 1'b0};

      // Reset state.
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      rst_n = 1'b1;
      idle(4);
      chk_zero("post_reset");

      foreach (vecs[i]) send_packet(vecs[i]);
      drain();

      // Bad stop bit on the 5th data frame, then the rest of the packet.
      for (int i = 0; i < 8; i++) begin
         send_frame(1'b0, data_byte(vecs[4], i), (i == 4) ? 1'b0 : 1'b1, sc);
         if (i == 4) push(EV_ERR_FRAME, sc);
      end
      send_frame(1'b1, {1'b0, vecs[4].op, vecs[4].crc}, 1'b1, sc);
      push(EV_ERR_DATA, sc);
      drain();
      send_packet(vecs[2]);
      drain();

      // Reset in the payload of the 6th frame.
      for (int i = 0; i < 5; i++) send_frame(1'b0, data_byte(vecs[6], i), 1'b1, sc);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      #2 rst_n = 1'b0;
      #1 chk_zero("async_reset");
      mdl_a   = '0;
      mdl_b   = '0;
      mdl_op  = '0;
      mdl_crc = '0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      send_packet(vecs[4]);
      drain();
      idle(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
